// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, data width and line levels.
// Shared by uart_tx and the future uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned DATA_BITS = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    assign tick = (r_count == LAST);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit (8E1).
// All outputs are registered so the line is glitch-free towards the radio.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       tx_ctrl,
    input  logic [7:0] tx_byte,
    output logic       transmit_ready,
    output logic       tx_serial,
    output logic       tx_done
);

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_tx_serial;
    logic       r_ready;
    logic       r_tx_done;
    logic       w_tick;
    logic       w_clear;

    // Idle holds the counter at zero; every other state leaves on a tick, so each
    // state change starts a fresh bit period.
    assign w_clear = (r_state == IDLE) || w_tick;

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_counter (
        .clk  (clk),
        .nRst (nRst),
        .clear(w_clear),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_tx_serial <= IDLE_LEVEL;
            r_ready     <= 1'b1;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (tx_ctrl && r_ready) begin
                        r_state     <= START;
                        r_shift     <= tx_byte;
                        r_tx_serial <= START_LEVEL;
                        r_ready     <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state     <= DATA;
                        r_tx_serial <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state     <= PARITY;
                            r_tx_serial <= ^r_shift;
`else
                            r_state     <= STOP;
                            r_tx_serial <= STOP_LEVEL;
`endif
                        end else begin
                            r_bit_idx   <= r_bit_idx + 3'd1;
                            r_tx_serial <= r_shift[r_bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_state     <= STOP;
                        r_tx_serial <= STOP_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_state     <= IDLE;
                        r_tx_serial <= IDLE_LEVEL;
                        r_ready     <= 1'b1;
                        r_tx_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_tx_serial <= IDLE_LEVEL;
                    r_ready     <= 1'b1;
                end
            endcase
        end
    end

    assign tx_serial      = r_tx_serial;
    assign transmit_ready = r_ready;
    assign tx_done        = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4; a line monitor decodes
// frames and compares them with a queue of bytes the stimulus expects to be sent.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk     = 1'b0;
    logic       nRst    = 1'b0;
    logic       tx_ctrl = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       transmit_ready;
    logic       tx_serial;
    logic       tx_done;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk           (clk),
        .nRst          (nRst),
        .tx_ctrl       (tx_ctrl),
        .tx_byte       (tx_byte),
        .transmit_ready(transmit_ready),
        .tx_serial     (tx_serial),
        .tx_done       (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for each bit slot of a frame, index 0 = start bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Line monitor
    int          cyc_n  = 0;
    bit          mon_on = 1'b0;
    int          mon_i  = 0;
    logic [43:0] samp;
    logic [7:0]  mon_b;
    logic [10:0] mon_f;

    always @(negedge clk) begin
        cyc_n++;
        if (!nRst) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (tx_serial == 1'b0) begin
                mon_on  = 1'b1;
                mon_i   = 1;
                samp    = '1;
                samp[0] = 1'b0;
                start_q.push_back(cyc_n);
            end
        end else if (mon_i < FB * CPB) begin
            samp[mon_i] = tx_serial;
            mon_i++;
        end else begin
            check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_b = exp_q.pop_front();
                mon_f = frame_bits(mon_b);
                for (int b = 0; b < FB; b++) begin
                    check_eq($sformatf("frame_%02h_bit%0d", mon_b, b),
                             32'(samp[b*CPB +: CPB]), 32'({CPB{mon_f[b]}}));
                end
            end
            check_eq("done_at_frame_end", 32'(tx_done), 32'd1);
            check_eq("ready_at_frame_end", 32'(transmit_ready), 32'd1);
            mon_on = 1'b0;
        end
    end

    task automatic send_pulse(input logic [7:0] b);
        @(posedge clk);
        #1;
        tx_byte = b;
        tx_ctrl = 1'b1;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        tx_ctrl = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!transmit_ready && n < 200);
        check_eq("ready_within_bound", 32'(transmit_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [10:0] f41;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_serial", 32'(tx_serial), 32'd1);
        check_eq("rst_ready", 32'(transmit_ready), 32'd1);
        check_eq("rst_done", 32'(tx_done), 32'd0);
        @(posedge clk);
        #1 nRst = 1'b1;
        repeat (3) @(posedge clk);

        // Single frame, cycle-exact
        f41 = frame_bits(8'h41);
        send_pulse(8'h41);
        for (int i = 0; i < FB * CPB; i++) begin
            @(negedge clk);
            check_eq($sformatf("h41_line_c%0d", i + 1), 32'(tx_serial), 32'(f41[i / CPB]));
            check_eq($sformatf("h41_busy_c%0d", i + 1), 32'(transmit_ready), 32'd0);
            check_eq($sformatf("h41_nodone_c%0d", i + 1), 32'(tx_done), 32'd0);
        end
        @(negedge clk);
        check_eq("h41_done_pulse", 32'(tx_done), 32'd1);
        check_eq("h41_ready_back", 32'(transmit_ready), 32'd1);
        check_eq("h41_line_idle", 32'(tx_serial), 32'd1);
        @(negedge clk);
        check_eq("h41_done_one_cycle", 32'(tx_done), 32'd0);
        repeat (4) @(posedge clk);

        // Back-to-back frames with tx_ctrl held high
        start_q.delete();
        @(posedge clk);
        #1;
        tx_byte = 8'h48;
        tx_ctrl = 1'b1;
        exp_q.push_back(8'h48);
        @(posedge clk);
        #1;
        tx_byte = 8'h49;
        exp_q.push_back(8'h49);
        wait_ready();
        @(posedge clk);
        #1 tx_ctrl = 1'b0;
        wait_ready();
        repeat (3) @(negedge clk);
        check_eq("b2b_frame_count", 32'(start_q.size()), 32'd2);
        if (start_q.size() >= 2)
            check_eq("b2b_start_gap", 32'(start_q[1] - start_q[0]), 32'(FB * CPB + 1));

        // Request while busy is ignored
        send_pulse(8'h00);
        repeat (10) @(posedge clk);
        #1;
        tx_byte = 8'hFF;
        tx_ctrl = 1'b1;
        @(posedge clk);
        #1 tx_ctrl = 1'b0;
        wait_ready();
        repeat (2 * FB * CPB) @(negedge clk);
        check_eq("busy_no_extra_frame", 32'(exp_q.size()), 32'd0);
        check_eq("busy_line_idle", 32'(tx_serial), 32'd1);

        // Reset in the middle of data bit 3
        send_pulse(8'hA5);
        repeat (4 * CPB + 2) @(negedge clk);
        #1 nRst = 1'b0;
        #1;
        check_eq("midrst_serial", 32'(tx_serial), 32'd1);
        check_eq("midrst_ready", 32'(transmit_ready), 32'd1);
        check_eq("midrst_done", 32'(tx_done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("postrst_serial", 32'(tx_serial), 32'd1);
        send_pulse(8'h5A);
        wait_ready();
        repeat (3) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        // Even parity: 8'h07 -> 1, 8'h03 -> 0
        send_pulse(8'h07);
        wait_ready();
        send_pulse(8'h03);
        wait_ready();
        repeat (3) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, giving clk cycles per serial bit (12 MHz / 9600 baud).
REQ-002 SHALL have port clk, input, 1: single system clock, rising-edge.
REQ-003 SHALL have port nRst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port tx_ctrl, input, 1: send request from msg_reg, sampled each cycle.
REQ-005 SHALL have port tx_byte, input, 8: byte to send, valid while tx_ctrl is high.
REQ-006 SHALL have port transmit_ready, output, 1: high when idle and able to accept a byte; feeds msg_reg.
REQ-007 SHALL have port tx_serial, output, 1: serial line to the radio module, idle high.
REQ-008 SHALL have port tx_done, output, 1: one-cycle pulse when a frame's stop bit completes.

Function
REQ-009 SHALL accept a byte on any cycle where tx_ctrl and transmit_ready are both high, latching tx_byte into an internal shift register.
REQ-010 SHALL ignore tx_ctrl while transmit_ready is low; the latched byte SHALL NOT change mid-frame.
REQ-011 SHALL use FSM states IDLE, START, DATA, PARITY, STOP: IDLE->START on accept, START->DATA, DATA->PARITY or STOP after bit 7, PARITY->STOP, STOP->IDLE.
REQ-012 SHALL drive tx_serial low in START, the current data bit in DATA (LSB first), the parity bit in PARITY, and high in STOP and IDLE.
REQ-013 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every state change.
REQ-014 SHALL make tx_serial fall on the first rising edge after the accept cycle (one-cycle latency).
REQ-015 SHALL drive transmit_ready low from the cycle after accept until the STOP bit ends.
REQ-016 SHALL return transmit_ready high and pulse tx_done high for one cycle on the same cycle the FSM enters IDLE.
REQ-017 SHALL accept a new byte on the first cycle transmit_ready is high (back-to-back frames), with no extra idle bit inserted.
REQ-018 SHALL keep the data bit index at 3 bits, wrapping 7->0 only on the DATA exit.
REQ-019 SHALL size the baud counter at $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1.

Reset
REQ-020 SHALL, while nRst is low, immediately force state IDLE, tx_serial=1, transmit_ready=1, tx_done=0, and clear the counter, bit index and shift register.
REQ-021 SHALL, on reset mid-frame, abandon the frame with no further bits driven; the line returns high asynchronously.

Configuration
REQ-022 SHALL, with UART_TX_PARITY_EN defined, include the PARITY state and send an even-parity bit (XOR of the 8 data bits) between bit 7 and STOP, giving an 11-bit frame.
REQ-023 SHALL, without UART_TX_PARITY_EN, go DATA->STOP directly, giving a 10-bit frame; PARITY SHALL be unreachable.

Structure
REQ-024 SHALL take the state enum (tx_state_t), DATA_BITS=8 and the IDLE_LEVEL/START_LEVEL/STOP_LEVEL constants from a shared package uart_pkg, which the future uart_rx will reuse.
REQ-025 SHALL put bit timing in one sub-module, baud_counter (inputs clk, nRst, clear; output tick at count CLKS_PER_BIT-1).

Verification (CLKS_PER_BIT=4)
REQ-026 SHALL check reset: nRst low -> tx_serial=1, transmit_ready=1, tx_done=0.
REQ-027 SHALL check a single frame: tx_byte=8'h41 with a one-cycle tx_ctrl pulse -> line 0,1,0,0,0,0,0,1,0,1 with each bit 4 cycles long; transmit_ready low for 40 cycles; tx_done pulse on cycle 41.
REQ-028 SHALL check back-to-back frames: tx_ctrl held high with 8'h48 then 8'h49 -> second start bit begins the cycle after the first stop bit ends, with no idle gap.
REQ-029 SHALL check busy-ignore: a tx_ctrl pulse with 8'hFF in the middle of an 8'h00 frame -> only 8'h00 is sent; the ignored byte is never sent.
REQ-030 SHALL check mid-frame reset: nRst low during data bit 3 of 8'hA5 -> tx_serial=1 at once; a new byte 8'h5A is sent correctly after nRst is released.
REQ-031 SHALL check parity with UART_TX_PARITY_EN: 8'h07 -> parity bit 1 and a 44-cycle frame; 8'h03 -> parity bit 0.
